// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: main control FSM for the multi-cycle MIPS datapath
// Ports:
//   clk, rst_n        rising-edge clock, synchronous active-low reset
//   opcode            IR[31:26], looked at in DECODE and MEMADR only
//   mem_ready         memory completes the current access this cycle
//   pc_write(_cond)   PC load enables (unconditional / on ALU zero)
//   i_or_d            memory address select: 0=PC, 1=ALUOut
//   mem_read/write    memory requests; ir_write loads IR
//   mem_to_reg        RF write data: 0=ALUOut, 1=MDR
//   reg_dst           RF write address: 0=rt, 1=rd; reg_write enables RF
//   alu_src_a/b       ALU operand selects; alu_op 00=add 01=sub 10=funct
//   pc_source         00=ALU result, 01=ALUOut, 10=jump target
//   halt              illegal-opcode trap, sticky until reset
//   instr_retired     retired-instruction count, wraps modulo 2^CNT_W
module mips_multicycle_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_to_reg,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic             halt,
    output logic [CNT_W-1:0] instr_retired
);
    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JUMP   = 4'd11,
        HALT   = 4'd12
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    state_t state, next_state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= FETCH;
            instr_retired <= '0;
        end else begin
            state <= next_state;
            if (next_state == FETCH && state != FETCH)
                instr_retired <= instr_retired + 1'b1;
        end
    end

    always_comb begin
        next_state    = state;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        halt          = 1'b0;
        case (state)
            FETCH: begin
                mem_read   = 1'b1;
                alu_src_b  = 2'b01;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
                next_state = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                alu_src_b  = 2'b11;
                next_state = (opcode == OP_R)                      ? EXEC   :
                             (opcode == OP_LW || opcode == OP_SW) ? MEMADR :
                             (opcode == OP_BEQ)                    ? BRANCH :
                             (opcode == OP_ADDI)                   ? ADDIEX :
                             (opcode == OP_J)                      ? JUMP   : HALT;
            end
            MEMADR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                // opcode is re-examined here; anything but lw/sw traps
                next_state = (opcode == OP_LW) ? MEMRD :
                             (opcode == OP_SW) ? MEMWR : HALT;
            end
            MEMRD: begin
                mem_read   = 1'b1;
                i_or_d     = 1'b1;
                next_state = mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                next_state = FETCH;
            end
            MEMWR: begin
                mem_write  = 1'b1;
                i_or_d     = 1'b1;
                next_state = mem_ready ? FETCH : MEMWR;
            end
            EXEC: begin
                alu_src_a  = 1'b1;
                alu_op     = 2'b10;
                next_state = ALUWB;
            end
            ALUWB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                next_state = FETCH;
            end
            BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                next_state    = FETCH;
            end
            ADDIEX: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                next_state = ADDIWB;
            end
            ADDIWB: begin
                reg_write  = 1'b1;
                next_state = FETCH;
            end
            JUMP: begin
                pc_write   = 1'b1;
                pc_source  = 2'b10;
                next_state = FETCH;
            end
            HALT: begin
                halt       = 1'b1;
                next_state = HALT;
            end
            default: next_state = HALT;
        endcase
        // reset overrides everything so an abandoned instruction writes nothing
        if (!rst_n) begin
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            i_or_d        = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            ir_write      = 1'b0;
            mem_to_reg    = 1'b0;
            reg_dst       = 1'b0;
            reg_write     = 1'b0;
            alu_src_a     = 1'b0;
            alu_src_b     = 2'b00;
            alu_op        = 2'b00;
            pc_source     = 2'b00;
            halt          = 1'b0;
        end
    end
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: directed self-checking bench for mips_multicycle_ctrl
module tb_mips_multicycle_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = 6'b0;
    logic       mem_ready = 1'b1;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, halt;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] instr_retired;
    logic [16:0] outv;
    int ntests = 0;
    int nfail = 0;

    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010, OP_BAD = 6'b111111;

    // pw pwc iord mr mw irw m2r rdst rw asa asb aop psrc halt
    localparam logic [16:0] O_ZERO   = 17'b0_0_0_0_0_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] O_FETCHW = 17'b0_0_0_1_0_0_0_0_0_0_01_00_00_0;
    localparam logic [16:0] O_FETCHR = 17'b1_0_0_1_0_1_0_0_0_0_01_00_00_0;
    localparam logic [16:0] O_DECODE = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
    localparam logic [16:0] O_MEMADR = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
    localparam logic [16:0] O_MEMRD  = 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] O_MEMWB  = 17'b0_0_0_0_0_0_1_0_1_0_00_00_00_0;
    localparam logic [16:0] O_MEMWR  = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] O_EXEC   = 17'b0_0_0_0_0_0_0_0_0_1_00_10_00_0;
    localparam logic [16:0] O_ALUWB  = 17'b0_0_0_0_0_0_0_1_1_0_00_00_00_0;
    localparam logic [16:0] O_BRANCH = 17'b0_1_0_0_0_0_0_0_0_1_00_01_01_0;
    localparam logic [16:0] O_ADDIEX = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
    localparam logic [16:0] O_ADDIWB = 17'b0_0_0_0_0_0_0_0_1_0_00_00_00_0;
    localparam logic [16:0] O_JUMP   = 17'b1_0_0_0_0_0_0_0_0_0_00_00_10_0;
    localparam logic [16:0] O_HALT   = 17'b0_0_0_0_0_0_0_0_0_0_00_00_00_1;

    mips_multicycle_ctrl #(.CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .halt(halt), .instr_retired(instr_retired)
    );

    assign outv = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
                   reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, halt};

    always #5 clk = ~clk;

    // one clock cycle: drive inputs after the falling edge, check outputs, let the rising edge act
    task automatic cyc(input string tag, input logic r, input logic rdy, input logic [5:0] op,
                       input logic [16:0] exp);
        @(negedge clk);
        rst_n = r;
        mem_ready = rdy;
        opcode = op;
        #1;
        ntests++;
        assert (outv === exp) else begin
            nfail++;
            $error("FAIL %s outputs=%b expected=%b", tag, outv, exp);
        end
    endtask

    task automatic chk_cnt(input string tag, input logic [3:0] exp);
        ntests++;
        assert (instr_retired === exp) else begin
            nfail++;
            $error("FAIL %s instr_retired=%0d expected=%0d", tag, instr_retired, exp);
        end
    endtask

    initial begin
        // reset held two cycles, then a j
        cyc("rst_a", 0, 1, OP_J, O_ZERO);
        chk_cnt("rst_a_cnt", 4'd0);
        cyc("rst_b", 0, 1, OP_J, O_ZERO);
        chk_cnt("rst_b_cnt", 4'd0);
        cyc("rel_fetch", 1, 1, OP_J, O_FETCHR);
        cyc("rel_decode", 1, 1, OP_J, O_DECODE);
        cyc("rel_jump", 1, 1, OP_J, O_JUMP);
        cyc("rel_fetch2", 1, 0, OP_J, O_FETCHW);
        chk_cnt("rel_cnt", 4'd1);

        // lw with memory stalls: 10 cycles
        cyc("lw_rst", 0, 1, OP_LW, O_ZERO);
        cyc("lw_fw0", 1, 0, OP_LW, O_FETCHW);
        chk_cnt("lw_cnt0", 4'd0);
        cyc("lw_fw1", 1, 0, OP_LW, O_FETCHW);
        cyc("lw_fw2", 1, 0, OP_LW, O_FETCHW);
        cyc("lw_fr", 1, 1, OP_LW, O_FETCHR);
        cyc("lw_dec", 1, 1, OP_LW, O_DECODE);
        cyc("lw_adr", 1, 1, OP_LW, O_MEMADR);
        cyc("lw_rd0", 1, 0, OP_BAD, O_MEMRD);
        cyc("lw_rd1", 1, 0, OP_BAD, O_MEMRD);
        cyc("lw_rd2", 1, 1, OP_BAD, O_MEMRD);
        cyc("lw_wb", 1, 1, OP_BAD, O_MEMWB);
        cyc("lw_next", 1, 0, OP_BAD, O_FETCHW);
        chk_cnt("lw_cnt", 4'd1);

        // R, sw, beq, addi, j back to back; opcode garbage where it must be ignored
        cyc("seq_rst", 0, 1, OP_R, O_ZERO);
        cyc("r_f", 1, 1, OP_BAD, O_FETCHR);
        cyc("r_dec", 1, 1, OP_R, O_DECODE);
        cyc("r_exec", 1, 1, OP_BAD, O_EXEC);
        cyc("r_wb", 1, 1, OP_BAD, O_ALUWB);
        cyc("sw_f", 1, 1, OP_SW, O_FETCHR);
        chk_cnt("seq_cnt1", 4'd1);
        cyc("sw_dec", 1, 1, OP_SW, O_DECODE);
        cyc("sw_adr", 1, 1, OP_SW, O_MEMADR);
        cyc("sw_wr", 1, 1, OP_BAD, O_MEMWR);
        cyc("beq_f", 1, 1, OP_BEQ, O_FETCHR);
        cyc("beq_dec", 1, 1, OP_BEQ, O_DECODE);
        cyc("beq_br", 1, 1, OP_BAD, O_BRANCH);
        cyc("addi_f", 1, 1, OP_ADDI, O_FETCHR);
        chk_cnt("seq_cnt3", 4'd3);
        cyc("addi_dec", 1, 1, OP_ADDI, O_DECODE);
        cyc("addi_ex", 1, 1, OP_BAD, O_ADDIEX);
        cyc("addi_wb", 1, 1, OP_BAD, O_ADDIWB);
        cyc("j_f", 1, 1, OP_J, O_FETCHR);
        cyc("j_dec", 1, 1, OP_J, O_DECODE);
        cyc("j_jump", 1, 1, OP_BAD, O_JUMP);
        cyc("seq_next", 1, 0, OP_BAD, O_FETCHW);
        chk_cnt("seq_cnt5", 4'd5);

        // illegal opcode traps, sticky until reset
        cyc("ill_rst", 0, 1, OP_BAD, O_ZERO);
        cyc("ill_f", 1, 1, OP_BAD, O_FETCHR);
        cyc("ill_dec", 1, 1, OP_BAD, O_DECODE);
        for (int i = 0; i < 20; i++) cyc("ill_halt", 1, 1, (i % 2 == 0) ? OP_J : OP_R, O_HALT);
        cyc("halt_rst", 0, 1, OP_SW, O_ZERO);
        cyc("halt_fetch", 1, 1, OP_SW, O_FETCHR);

        // reset while a store is waiting on memory
        cyc("swr_dec", 1, 1, OP_SW, O_DECODE);
        cyc("swr_adr", 1, 1, OP_SW, O_MEMADR);
        cyc("swr_wr", 1, 0, OP_SW, O_MEMWR);
        cyc("swr_rst", 0, 1, OP_SW, O_ZERO);
        cyc("swr_after", 1, 0, OP_SW, O_FETCHW);
        chk_cnt("swr_cnt", 4'd0);

        // 17 jumps wrap the 4-bit counter
        cyc("wrap_rst", 0, 1, OP_J, O_ZERO);
        for (int i = 0; i < 17; i++) begin
            cyc("wrap_f", 1, 1, OP_J, O_FETCHR);
            chk_cnt("wrap_cnt", 4'(i));
            cyc("wrap_dec", 1, 1, OP_J, O_DECODE);
            cyc("wrap_jump", 1, 1, OP_J, O_JUMP);
        end
        cyc("wrap_end", 1, 0, OP_J, O_FETCHW);
        chk_cnt("wrap_cnt17", 4'd1);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Main control FSM for the multi-cycle MIPS datapath.
- Sequences shared datapath resources (single memory port, single ALU, PC/IR/register-file write enables) across FETCH/DECODE/EXECUTE/MEM/WB cycles.
- Drives every 2:1 and 4:1 mux select in the datapath.
- Stalls on a memory ready handshake, counts retired instructions and halts on unsupported opcodes.

Parameters:
- CNT_W, 16, width of retired-instruction counter (wraps modulo 2^CNT_W)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  synchronous active-low reset
- opcode  input  6  IR[31:26], valid from DECODE onward
- mem_ready  input  1  memory completes current access this cycle
- pc_write  output  1  unconditional PC load
- pc_write_cond  output  1  PC load if ALU zero (beq)
- i_or_d  output  1  mem address mux: 0=PC, 1=ALUOut
- mem_read  output  1  memory read request
- mem_write  output  1  memory write request
- ir_write  output  1  IR load
- mem_to_reg  output  1  RF write-data mux: 0=ALUOut, 1=MDR
- reg_dst  output  1  RF write-addr mux: 0=rt, 1=rd
- reg_write  output  1  RF write enable
- alu_src_a  output  1  0=PC, 1=A
- alu_src_b  output  2  00=B, 01=4, 10=signext, 11=signext<<2
- alu_op  output  2  00=add, 01=sub, 10=funct-decoded
- pc_source  output  2  00=ALU result, 01=ALUOut, 10=jump target
- halt  output  1  illegal opcode trap
- instr_retired  output  CNT_W  retired-instruction count

Behaviour:
- Synchronous active-low reset: state<=FETCH, instr_retired<=0, halt<=0. While rst_n=0, all enables (pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write) are forced 0 and all selects/alu_op are 0. Reset mid-instruction abandons it without any write.
- States (4-bit encoding):
  - FETCH=0
  - DECODE=1
  - MEMADR=2
  - MEMRD=3
  - MEMWB=4
  - MEMWR=5
  - EXEC=6
  - ALUWB=7
  - BRANCH=8
  - ADDIEX=9
  - ADDIWB=10
  - JUMP=11
  - HALT=12
- Outputs not listed for a state are 0.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00. ir_write=pc_write=mem_ready (Mealy). Stay in FETCH while mem_ready=0; go to DECODE when 1.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00. Next state by opcode:
  - 000000 -> EXEC
  - 100011 or 101011 -> MEMADR
  - 000100 -> BRANCH
  - 001000 -> ADDIEX
  - 000010 -> JUMP
  - any other -> HALT
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Next: lw -> MEMRD, sw -> MEMWR.
- MEMRD: mem_read=1, i_or_d=1. Wait until mem_ready, then MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0. Next: FETCH.
- MEMWR: mem_write=1, i_or_d=1. Wait until mem_ready, then FETCH.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Next: ALUWB.
- ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0. Next: FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01. Next: FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00. Next: ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0. Next: FETCH.
- JUMP: pc_write=1, pc_source=10. Next: FETCH.
- HALT: halt=1, all enables 0. Absorbing; exits only by reset.
- instr_retired increments by 1 on every transition into FETCH from a non-FETCH state. Reset->FETCH does not count. Wraps from all-ones to 0.
- Cycle counts with mem_ready tied 1:
  - R-type 4
  - lw 5
  - sw 4
  - beq 3
  - addi 4
  - j 3
- Unreachable encodings 13-15 go to HALT next cycle.
- opcode is sampled only in DECODE and MEMADR. Changes elsewhere have no effect.

Test Plan:
- Reset: hold rst_n=0 2 cycles with mem_ready=1 -> all enables 0, instr_retired=0, halt=0. First cycle after release: FETCH, mem_read=1, pc_write=1, ir_write=1.
- lw (opcode=100011), mem_ready=0 for 3 cycles in FETCH and 2 cycles in MEMRD -> FETCH held 4 cycles with ir_write=0 until ready. MEMWB asserts reg_write=1, mem_to_reg=1. Total 10 cycles; instr_retired=1.
- Sequence R-type, sw(101011), beq(000100), addi(001000), j(000010), mem_ready=1 -> state traces 0-1-6-7, 0-1-2-5, 0-1-8, 0-1-9-10, 0-1-11. beq asserts pc_write_cond=1, alu_op=01. j asserts pc_source=10. instr_retired=5 after 18 cycles.
- Illegal opcode 111111 -> HALT after DECODE, halt=1 persists 20 cycles with mem_read=0. rst_n=0 one cycle -> FETCH, halt=0.
- Reset in MEMWR (rst_n=0 at that cycle) -> mem_write=0 same cycle, next state FETCH, instr_retired=0.
- Counter wrap with CNT_W=4: 17 j instructions -> instr_retired = 0 after the 16th, 1 after the 17th.
